// File: rtl/pc_bpu_pkg.sv
// Shared definitions for the fetch PC unit: counter encodings, default BTB
// geometry and the saturating 2-bit counter step.
package pc_bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    localparam int DEF_PC_WIDTH    = 32;
    localparam int DEF_BTB_ENTRIES = 16;
    localparam int DEF_TAG_WIDTH   = 10;
    localparam int PC_INC          = 4;

    function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == ST) ? c : c + 2'd1;
        end
        return (c == SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_bpu_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC and
// a training port fed from EX, one write per cycle.
module pc_bpu_btb
    import pc_bpu_pkg::*;
#(
    parameter int         PC_WIDTH    = DEF_PC_WIDTH,
    parameter int         BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int         TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter logic [1:0] CNT_INIT    = WNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                lookup_taken,
    output logic [PC_WIDTH-1:0] lookup_target,
    input  logic                train_en,
    input  logic [PC_WIDTH-1:0] train_pc,
    input  logic                train_taken,
    input  logic                train_jmp,
    input  logic [PC_WIDTH-1:0] train_target
);

    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_LO + TAG_WIDTH - 1;

    logic [BTB_ENTRIES-1:0]        valid_q;
    logic [BTB_ENTRIES-1:0]        jmp_q;
    logic [BTB_ENTRIES-1:0][1:0]   cnt_q;
    logic [TAG_WIDTH-1:0]          tag_q    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]           target_q [BTB_ENTRIES];

    logic [IDX_W-1:0]     lk_idx, tr_idx;
    logic [TAG_WIDTH-1:0] lk_tag, tr_tag;
    logic                 lk_hit, tr_hit;
    logic                 unused_lk, unused_tr;

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[TAG_HI:TAG_LO];
    assign tr_idx    = train_pc[IDX_W+1:2];
    assign tr_tag    = train_pc[TAG_HI:TAG_LO];
    // Byte-offset and above-tag bits take no part in indexing or matching.
    assign unused_lk = ^{lookup_pc[1:0], lookup_pc >> (TAG_HI + 1)};
    assign unused_tr = ^{train_pc[1:0], train_pc >> (TAG_HI + 1)};

    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign tr_hit        = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);
    assign lookup_taken  = lk_hit && (jmp_q[lk_idx] || cnt_q[lk_idx][1]);
    assign lookup_target = target_q[lk_idx];

    // Control state: valid bits and counters are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= {BTB_ENTRIES{CNT_INIT}};
        end else if (train_en) begin
            if (tr_hit) begin
                cnt_q[tr_idx] <= cnt_next(cnt_q[tr_idx], train_taken);
            end else if (train_taken) begin
                valid_q[tr_idx] <= 1'b1;
                cnt_q[tr_idx]   <= train_jmp ? 2'(WT) : cnt_next(CNT_INIT, 1'b1);
            end
        end
    end

    // Payload: only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && train_en && train_taken) begin
            tag_q[tr_idx]    <= tr_tag;
            target_q[tr_idx] <= train_target;
            jmp_q[tr_idx]    <= train_jmp;
        end
    end

endmodule

// File: rtl/pc_bpu.sv
// Fetch PC register with BTB-based prediction, EX mispredict detection and
// the next-pc priority mux.
module pc_bpu
    import pc_bpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                  BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int                  TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [1:0]          CNT_INIT    = WNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic                pc_stall,
    input  logic                ctrl_redirect,
    input  logic [PC_WIDTH-1:0] ctrl_pc,
    input  logic                ex_valid,
    input  logic                ex_is_jmp,
    input  logic [PC_WIDTH-1:0] ex_pc,
    input  logic                ex_taken,
    input  logic [PC_WIDTH-1:0] ex_target,
    input  logic                ex_predt_taken,
    input  logic [PC_WIDTH-1:0] ex_predt_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                predt_taken,
    output logic [PC_WIDTH-1:0] predt_target,
    output logic                mispredict
);

    logic [PC_WIDTH-1:0] pc_q, pc_next, pc_inc, redirect_pc, btb_target;
    logic                btb_taken;

    pc_bpu_btb #(
        .PC_WIDTH    (PC_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES),
        .TAG_WIDTH   (TAG_WIDTH),
        .CNT_INIT    (CNT_INIT)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (pc_q),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .train_en      (cpu_en && ex_valid),
        .train_pc      (ex_pc),
        .train_taken   (ex_taken),
        .train_jmp     (ex_is_jmp),
        .train_target  (ex_target)
    );

    assign pc           = pc_q;
    assign pc_inc       = pc_q + PC_WIDTH'(PC_INC);
    assign predt_taken  = btb_taken;
    assign predt_target = btb_taken ? btb_target : pc_inc;

    assign mispredict  = ex_valid && ((ex_taken != ex_predt_taken) ||
                                      (ex_taken && (ex_target != ex_predt_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_WIDTH'(PC_INC);

    // A mispredict beats a stall: the stalled instruction is being flushed.
    always_comb begin
        pc_next = pc_inc;
        if (ctrl_redirect) begin
            pc_next = ctrl_pc;
        end else if (mispredict) begin
            pc_next = redirect_pc;
        end else if (pc_stall) begin
            pc_next = pc_q;
        end else if (predt_taken) begin
            pc_next = predt_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (cpu_en) begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_bpu.sv
// Directed bench for pc_bpu: sequential pc, BTB training, counter saturation,
// redirect priority, aliasing, jumps and mid-run reset.
module tb_pc_bpu;

    logic        clk = 1'b0;
    logic        rst, cpu_en, pc_stall, ctrl_redirect;
    logic [31:0] ctrl_pc;
    logic        ex_valid, ex_is_jmp, ex_taken, ex_predt_taken;
    logic [31:0] ex_pc, ex_target, ex_predt_target;
    logic [31:0] pc, predt_target;
    logic        predt_taken, mispredict;

    int n_cmp = 0;
    int n_bad = 0;

    pc_bpu dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_en          (cpu_en),
        .pc_stall        (pc_stall),
        .ctrl_redirect   (ctrl_redirect),
        .ctrl_pc         (ctrl_pc),
        .ex_valid        (ex_valid),
        .ex_is_jmp       (ex_is_jmp),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_predt_taken  (ex_predt_taken),
        .ex_predt_target (ex_predt_target),
        .pc              (pc),
        .predt_taken     (predt_taken),
        .predt_target    (predt_target),
        .mispredict      (mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic j, input logic [31:0] p, input logic t,
                          input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        ex_valid = v; ex_is_jmp = j; ex_pc = p; ex_taken = t;
        ex_target = tg; ex_predt_taken = pt; ex_predt_target = ptg;
        #1;
    endtask

    task automatic goto(input logic [31:0] a);
        ctrl_redirect = 1'b1; ctrl_pc = a;
        step();
        ctrl_redirect = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b1; pc_stall = 1'b0; ctrl_redirect = 1'b0; ctrl_pc = '0;
        ex_set(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("reset_pc", pc, 32'h0);
        check("reset_predt", {31'b0, predt_taken}, 0);
        check("reset_mispredict", {31'b0, mispredict}, 0);

        // sequential fetch
        step(); check("seq_pc4", pc, 32'h4);
        step(); check("seq_pc8", pc, 32'h8);
        step(); check("seq_pcC", pc, 32'hC);
        check("seq_predt", {31'b0, predt_taken}, 0);
        check("seq_ptarget", predt_target, 32'h10);

        // first taken training at 0x10 -> allocation with counter WT
        ex_set(1, 0, 32'h10, 1, 32'h40, 0, 0);
        check("train_mispredict", {31'b0, mispredict}, 1);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("train_redirect", pc, 32'h40);
        goto(32'h10);
        check("hit_predt", {31'b0, predt_taken}, 1);
        check("hit_ptarget", predt_target, 32'h40);
        step();
        check("hit_next_pc", pc, 32'h40);

        // saturation: 3 more taken, then decay by not-taken, pc stalled at 0x10
        goto(32'h10);
        pc_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_set(1, 0, 32'h10, 1, 32'h40, 1, 32'h40);
            step();
        end
        check("sat_no_mispredict", {31'b0, mispredict}, 0);
        ex_set(1, 0, 32'h10, 0, 32'h40, 0, 32'h14);
        check("nt_no_mispredict", {31'b0, mispredict}, 0);
        step();
        check("sat_then_nt1", {31'b0, predt_taken}, 1);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("nt2_predt", {31'b0, predt_taken}, 0);
        check("nt2_ptarget", predt_target, 32'h14);
        check("stall_hold", pc, 32'h10);
        pc_stall = 1'b0;

        // priority: ctrl_redirect beats mispredict
        ctrl_redirect = 1'b1; ctrl_pc = 32'h100;
        ex_set(1, 0, 32'h30, 0, 0, 1, 32'h50);
        check("prio_mispredict", {31'b0, mispredict}, 1);
        step();
        ctrl_redirect = 1'b0;
        check("prio_ctrl", pc, 32'h100);
        // mispredict beats stall
        pc_stall = 1'b1;
        ex_set(1, 0, 32'h30, 1, 32'h300, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("prio_mp_stall", pc, 32'h300);
        // stall alone holds
        step();
        check("prio_stall_hold", pc, 32'h300);
        // cpu_en low holds everything
        pc_stall = 1'b0; cpu_en = 1'b0;
        step();
        check("cpu_en_hold", pc, 32'h300);
        cpu_en = 1'b1;

        // aliasing: restore 0x10 to taken, then evict with 0x410
        ex_set(1, 0, 32'h10, 1, 32'h40, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        goto(32'h10);
        check("alias_pre_predt", {31'b0, predt_taken}, 1);
        pc_stall = 1'b1;
        ex_set(1, 0, 32'h410, 1, 32'h80, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("alias_redirect", pc, 32'h80);
        goto(32'h10);
        check("alias_evicted", {31'b0, predt_taken}, 0);
        goto(32'h410);
        check("alias_new_predt", {31'b0, predt_taken}, 1);
        check("alias_new_target", predt_target, 32'h80);
        ex_set(1, 0, 32'h810, 0, 0, 0, 0);
        check("nt_miss_no_mp", {31'b0, mispredict}, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("nt_miss_keep", {31'b0, predt_taken}, 1);
        check("nt_miss_target", predt_target, 32'h80);
        pc_stall = 1'b0;

        // jal at 0x20, then reset clears the BTB
        ex_set(1, 1, 32'h20, 1, 32'h200, 0, 0);
        step();
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("jal_redirect", pc, 32'h200);
        goto(32'h20);
        check("jal_predt", {31'b0, predt_taken}, 1);
        check("jal_ptarget", predt_target, 32'h200);
        rst = 1'b1;
        ex_set(1, 1, 32'h20, 1, 32'h200, 0, 0);
        step();
        rst = 1'b0;
        ex_set(0, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h0);
        goto(32'h20);
        check("rst_miss", {31'b0, predt_taken}, 0);
        check("rst_ptarget", predt_target, 32'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
